// File: rtl/tuart_rx_cmd.sv
// -----------------------------------------------------------------------------
// tuart_rx_cmd
//   SUMP command receiver (2nd gen). UART receiver with a runtime baud divisor,
//   start-glitch rejection, framing-error detection and an inter-byte timeout,
//   followed by SUMP short/long command assembly. It sits between the
//   synchronised RX pin and the LogIP core command decoder.
//
//   Optional feature macro: TUART_RX_PARITY_EN
//     defined   -> parity_en_i / parity_odd_i / parity_err_o exist and a parity
//                  bit is expected after the data bits whenever parity_en_i was
//                  high at start detection.
//     undefined -> character is start + DATA_BITS + stop only.
//
// Ports
//   clk_i         system clock
//   rst_i         asynchronous reset, active high
//   rx_sync_i     RX line, already synchronised, idle high
//   div_i         clocks per bit (values below 4 are treated as 4)
//   parity_en_i   parity bit present             (TUART_RX_PARITY_EN only)
//   parity_odd_i  1 = odd parity, 0 = even       (TUART_RX_PARITY_EN only)
//   data_o        assembled command, opcode in the top slot (registered)
//   stb_o         1-cycle pulse, data_o holds a new command
//   parity_err_o  1-cycle pulse, parity mismatch (TUART_RX_PARITY_EN only)
//   frame_err_o   1-cycle pulse, stop bit sampled low
// -----------------------------------------------------------------------------
module tuart_rx_cmd #(
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned CMD_WIDTH_WORDS = 5,
  parameter int unsigned DIV_WIDTH       = 16,
  parameter int unsigned TIMEOUT_BITS    = 20
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 rx_sync_i,
  input  logic [DIV_WIDTH-1:0]                 div_i,
`ifdef TUART_RX_PARITY_EN
  input  logic                                 parity_en_i,
  input  logic                                 parity_odd_i,
`endif
  output logic [DATA_BITS*CMD_WIDTH_WORDS-1:0] data_o,
  output logic                                 stb_o,
`ifdef TUART_RX_PARITY_EN
  output logic                                 parity_err_o,
`endif
  output logic                                 frame_err_o
);

  localparam int unsigned OUT_WIDTH = DATA_BITS * CMD_WIDTH_WORDS;
  localparam int unsigned BIT_W     = $clog2(DATA_BITS + 1);
  localparam int unsigned WC_W      = $clog2(CMD_WIDTH_WORDS + 1);
  // Wide enough for TIMEOUT_BITS * (2**DIV_WIDTH - 1).
  localparam int unsigned IDLE_W    = DIV_WIDTH + $clog2(TIMEOUT_BITS + 1);
  localparam int unsigned DIV_MIN   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef TUART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t                 state_q, state_d;

  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   smpl_cnt_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic [WC_W-1:0]        word_cnt_q;
  logic [OUT_WIDTH-1:0]   asm_q;
  logic [IDLE_W-1:0]      idle_cnt_q;

`ifdef TUART_RX_PARITY_EN
  logic                   par_en_q;
  logic                   par_odd_q;
  logic                   par_bit_q;
`endif

  // Derived timing values
  logic [DIV_WIDTH-1:0]   div_eff;
  logic [DIV_WIDTH-1:0]   half_lim;
  logic [DIV_WIDTH-1:0]   full_lim;
  logic                   hit_half;
  logic                   hit_full;
  logic                   last_bit;
  logic [IDLE_W-1:0]      timeout_lim;
  logic                   timeout_hit;
  logic                   par_mismatch;

  // FSM control strobes
  logic start_det;
  logic go_data;
  logic data_smpl;
  logic par_smpl;
  logic stop_ok;
  logic stop_ferr;
  logic stop_perr;
  logic idle_inc;
  logic timeout_clr;
  logic smpl_inc;

  // Assembly
  logic [31:0]            slot_sh;
  logic [OUT_WIDTH-1:0]   asm_base;
  logic [OUT_WIDTH-1:0]   asm_nxt;
  logic                   cmd_done;

  always_comb begin
    div_eff     = (div_i < DIV_WIDTH'(DIV_MIN)) ? DIV_WIDTH'(DIV_MIN) : div_i;
    half_lim    = (div_q >> 1) - DIV_WIDTH'(1);
    full_lim    = div_q - DIV_WIDTH'(1);
    hit_half    = (smpl_cnt_q == half_lim);
    hit_full    = (smpl_cnt_q == full_lim);
    last_bit    = (bit_cnt_q == BIT_W'(DATA_BITS - 1));
    timeout_lim = IDLE_W'(TIMEOUT_BITS) * IDLE_W'(div_q);
    timeout_hit = (idle_cnt_q >= (timeout_lim - IDLE_W'(1)));
`ifdef TUART_RX_PARITY_EN
    // Even parity: parity bit equals XOR of data; odd parity: its inverse.
    par_mismatch = par_en_q && (par_bit_q != ((^shreg_q) ^ par_odd_q));
`else
    par_mismatch = 1'b0;
`endif
  end

  // Slot of the incoming byte: opcode at the top, later bytes move down.
  always_comb begin
    slot_sh  = DATA_BITS * (CMD_WIDTH_WORDS - 1 - 32'(word_cnt_q));
    asm_base = (word_cnt_q == '0) ? '0 : asm_q;
    asm_nxt  = asm_base | (OUT_WIDTH'(shreg_q) << slot_sh);
    cmd_done = ((word_cnt_q == '0) && !shreg_q[DATA_BITS-1]) ||
               (32'(word_cnt_q) == CMD_WIDTH_WORDS - 1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_det   = 1'b0;
    go_data     = 1'b0;
    data_smpl   = 1'b0;
    par_smpl    = 1'b0;
    stop_ok     = 1'b0;
    stop_ferr   = 1'b0;
    stop_perr   = 1'b0;
    idle_inc    = 1'b0;
    timeout_clr = 1'b0;
    smpl_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Start detection takes priority over a timeout in the same cycle.
        if (!rx_sync_i) begin
          start_det = 1'b1;
          state_d   = ST_START;
        end else if (word_cnt_q != '0) begin
          if (timeout_hit) begin
            timeout_clr = 1'b1;
          end else begin
            idle_inc = 1'b1;
          end
        end
      end

      ST_START: begin
        if (hit_half) begin
          if (rx_sync_i) begin
            state_d = ST_IDLE;
          end else begin
            go_data = 1'b1;
            state_d = ST_DATA;
          end
        end else begin
          smpl_inc = 1'b1;
        end
      end

      ST_DATA: begin
        if (hit_full) begin
          data_smpl = 1'b1;
          if (last_bit) begin
`ifdef TUART_RX_PARITY_EN
            state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          smpl_inc = 1'b1;
        end
      end

`ifdef TUART_RX_PARITY_EN
      ST_PARITY: begin
        if (hit_full) begin
          par_smpl = 1'b1;
          state_d  = ST_STOP;
        end else begin
          smpl_inc = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (hit_full) begin
          if (!rx_sync_i) begin
            stop_ferr = 1'b1;
            state_d   = ST_WAIT_HIGH;
          end else if (par_mismatch) begin
            stop_perr = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_ok = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          smpl_inc = 1'b1;
        end
      end

      ST_WAIT_HIGH: begin
        if (rx_sync_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q        <= '0;
      smpl_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      word_cnt_q   <= '0;
      asm_q        <= '0;
      idle_cnt_q   <= '0;
      data_o       <= '0;
      stb_o        <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef TUART_RX_PARITY_EN
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      stb_o        <= 1'b0;
      frame_err_o  <= stop_ferr;
`ifdef TUART_RX_PARITY_EN
      parity_err_o <= stop_perr;
`endif

      if (start_det) begin
        div_q <= div_eff;
`ifdef TUART_RX_PARITY_EN
        par_en_q  <= parity_en_i;
        par_odd_q <= parity_odd_i;
`endif
      end

      if (start_det || go_data || data_smpl || par_smpl) begin
        smpl_cnt_q <= '0;
      end else if (smpl_inc) begin
        smpl_cnt_q <= smpl_cnt_q + DIV_WIDTH'(1);
      end

      if (go_data) begin
        bit_cnt_q <= '0;
      end else if (data_smpl) begin
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end

      // LSB arrives first, so shift in from the top.
      if (data_smpl) begin
        shreg_q <= {rx_sync_i, shreg_q[DATA_BITS-1:1]};
      end

`ifdef TUART_RX_PARITY_EN
      if (par_smpl) begin
        par_bit_q <= rx_sync_i;
      end
`endif

      if (start_det || timeout_clr) begin
        idle_cnt_q <= '0;
      end else if (idle_inc) begin
        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
      end

      if (stop_ferr || stop_perr || timeout_clr) begin
        word_cnt_q <= '0;
        asm_q      <= '0;
      end else if (stop_ok) begin
        if (cmd_done) begin
          data_o     <= asm_nxt;
          stb_o      <= 1'b1;
          word_cnt_q <= '0;
          asm_q      <= '0;
        end else begin
          asm_q      <= asm_nxt;
          word_cnt_q <= word_cnt_q + WC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tuart_rx_cmd.sv
module tb_tuart_rx_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] div;
  logic [39:0] data;
  logic        stb;
  logic        ferr;
`ifdef TUART_RX_PARITY_EN
  logic        par_en;
  logic        par_odd;
  logic        perr;
`endif

  int total = 0;
  int bad   = 0;
  int stb_cnt  = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [39:0] got_q[$];

  tuart_rx_cmd #(
    .DATA_BITS(8),
    .CMD_WIDTH_WORDS(5),
    .DIV_WIDTH(16),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_sync_i(rx),
    .div_i(div),
`ifdef TUART_RX_PARITY_EN
    .parity_en_i(par_en),
    .parity_odd_i(par_odd),
`endif
    .data_o(data),
    .stb_o(stb),
`ifdef TUART_RX_PARITY_EN
    .parity_err_o(perr),
`endif
    .frame_err_o(ferr)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (stb) begin
      stb_cnt++;
      got_q.push_back(data);
    end
    if (ferr) ferr_cnt++;
`ifdef TUART_RX_PARITY_EN
    if (perr) perr_cnt++;
`endif
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          dv;
    int          nbytes;
    logic [39:0] bytes;     // first byte sent in the top 8 bits
    int          exp_stb;
    logic [39:0] exp_data;
  } vec_t;

  function automatic int eff(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // par_mode: 0 no parity bit, 1 correct parity bit, 2 inverted parity bit
  task automatic send_char(input logic [7:0] b, input int dv, input bit stop_val,
                           input int low_extra, input int par_mode);
    int d;
    d = eff(dv);
    div = 16'(dv);
`ifdef TUART_RX_PARITY_EN
    par_en = (par_mode != 0);
`endif
    rx = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (d) @(negedge clk);
    end
`ifdef TUART_RX_PARITY_EN
    if (par_mode != 0) begin
      logic pb;
      pb = par_odd ? ~(^b) : (^b);
      if (par_mode == 2) pb = ~pb;
      rx = pb;
      repeat (d) @(negedge clk);
    end
`endif
    rx = stop_val;
    repeat (d) @(negedge clk);
    if (!stop_val) repeat (low_extra) @(negedge clk);
    rx = 1'b1;
  endtask

  vec_t        tbl[8];
  logic [39:0] exp_q[$];
  logic [7:0]  pend[$];

  initial begin
    int s0, f0, p0, base;
    logic [39:0] bv;
    logic [7:0]  bb;

    rst = 1'b1;
    rx  = 1'b1;
    div = 16'd10;
`ifdef TUART_RX_PARITY_EN
    par_en  = 1'b0;
    par_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_data", data, 0);
    check("reset_stb", stb, 0);
    check("reset_ferr", ferr, 0);
    rst = 1'b0;
    idle(5);

    // ---------------- table-driven commands ----------------
    tbl[0] = '{10, 1, 40'h1100000000, 1, 40'h1100000000};
    tbl[1] = '{10, 5, 40'hC001020304, 1, 40'hC001020304};
    tbl[2] = '{2,  1, 40'h7F00000000, 1, 40'h7F00000000};
    tbl[3] = '{3,  5, 40'h80FF00AA55, 1, 40'h80FF00AA55};
    tbl[4] = '{17, 1, 40'h0000000000, 1, 40'h0000000000};
    tbl[5] = '{0,  5, 40'hFFFFFFFFFF, 1, 40'hFFFFFFFFFF};
    tbl[6] = '{10, 2, 40'h1234000000, 2, 40'h3400000000};
    tbl[7] = '{33, 5, 40'hA55A3CC301, 1, 40'hA55A3CC301};
    for (int i = 0; i < 8; i++) begin
      s0 = stb_cnt;
      f0 = ferr_cnt;
      bv = tbl[i].bytes;
      for (int k = 0; k < tbl[i].nbytes; k++) begin
        bb = bv[39-8*k -: 8];
        send_char(bb, tbl[i].dv, 1'b1, 0, 0);
        idle(2);
      end
      idle(3 * eff(tbl[i].dv));
      check($sformatf("vec%0d_stb", i), stb_cnt - s0, tbl[i].exp_stb);
      check($sformatf("vec%0d_data", i), data, tbl[i].exp_data);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, 0);
    end

    // ---------------- start glitch ----------------
    s0 = stb_cnt; f0 = ferr_cnt;
    div = 16'd10;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    check("glitch_stb", stb_cnt - s0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    send_char(8'h2A, 10, 1'b1, 0, 0);
    idle(30);
    check("glitch_next_stb", stb_cnt - s0, 1);
    check("glitch_next_data", data, 40'h2A00000000);

    // ---------------- framing error, held break ----------------
    s0 = stb_cnt; f0 = ferr_cnt;
    send_char(8'hC0, 10, 1'b0, 50, 0);
    idle(20);
    send_char(8'h11, 10, 1'b1, 0, 0);
    idle(30);
    check("ferr_cnt", ferr_cnt - f0, 1);
    check("ferr_next_stb", stb_cnt - s0, 1);
    check("ferr_next_data", data, 40'h1100000000);

    // framing error discards a partial long command
    s0 = stb_cnt; f0 = ferr_cnt;
    send_char(8'hC0, 10, 1'b1, 0, 0); idle(2);
    send_char(8'h01, 10, 1'b1, 0, 0); idle(2);
    send_char(8'h05, 10, 1'b0, 5, 0); idle(10);
    send_char(8'h33, 10, 1'b1, 0, 0); idle(30);
    check("ferr_partial_ferr", ferr_cnt - f0, 1);
    check("ferr_partial_stb", stb_cnt - s0, 1);
    check("ferr_partial_data", data, 40'h3300000000);

    // ---------------- inter-byte timeout ----------------
    s0 = stb_cnt;
    send_char(8'hC0, 10, 1'b1, 0, 0); idle(2);
    send_char(8'h01, 10, 1'b1, 0, 0);
    idle(200);
    send_char(8'h11, 10, 1'b1, 0, 0); idle(30);
    check("timeout_stb", stb_cnt - s0, 1);
    check("timeout_data", data, 40'h1100000000);

    s0 = stb_cnt;
    send_char(8'hC0, 10, 1'b1, 0, 0); idle(2);
    send_char(8'h01, 10, 1'b1, 0, 0);
    idle(150);
    send_char(8'h02, 10, 1'b1, 0, 0); idle(2);
    send_char(8'h03, 10, 1'b1, 0, 0); idle(2);
    send_char(8'h04, 10, 1'b1, 0, 0); idle(30);
    check("no_timeout_stb", stb_cnt - s0, 1);
    check("no_timeout_data", data, 40'hC001020304);

    // ---------------- reset mid-DATA ----------------
    send_char(8'hC0, 10, 1'b1, 0, 0); idle(2);
    div = 16'd10;
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = ((i % 2) == 0);
      repeat (10) @(negedge clk);
    end
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_data", data, 0);
    check("midrst_stb", stb, 0);
    check("midrst_ferr", ferr, 0);
    rst = 1'b0;
    idle(10);
    s0 = stb_cnt;
    send_char(8'h11, 10, 1'b1, 0, 0); idle(30);
    check("midrst_next_stb", stb_cnt - s0, 1);
    check("midrst_next_data", data, 40'h1100000000);

`ifdef TUART_RX_PARITY_EN
    // ---------------- parity ----------------
    s0 = stb_cnt; p0 = perr_cnt;
    par_odd = 1'b1;
    send_char(8'h11, 10, 1'b1, 0, 2); idle(30);
    check("par_odd_bad_perr", perr_cnt - p0, 1);
    check("par_odd_bad_stb", stb_cnt - s0, 0);
    send_char(8'h11, 10, 1'b1, 0, 1); idle(30);
    check("par_odd_ok_stb", stb_cnt - s0, 1);
    check("par_odd_ok_perr", perr_cnt - p0, 1);
    par_odd = 1'b0;
    send_char(8'h13, 10, 1'b1, 0, 1); idle(30);
    check("par_even_ok_data", data, 40'h1300000000);
    send_char(8'h13, 10, 1'b1, 0, 2); idle(30);
    check("par_even_bad_perr", perr_cnt - p0, 2);
    check("par_even_stb", stb_cnt - s0, 2);
`else
    p0 = perr_cnt;
    check("no_parity_perr", perr_cnt - p0 + ferr_cnt - ferr_cnt, 0);
`endif

    // ---------------- randomized traffic vs reference model ----------------
    idle(20);
    base = got_q.size();
    s0 = stb_cnt; f0 = ferr_cnt;
    exp_q.delete();
    pend.delete();
    begin
      int nferr;
      nferr = 0;
      for (int n = 0; n < 40; n++) begin
        int  dv, d, gap;
        bit  badstop, longgap;
        logic [7:0] b;
        dv = $urandom_range(1, 16);
        d  = eff(dv);
        b  = 8'($urandom_range(0, 255));
        badstop = ($urandom_range(0, 7) == 0);
        longgap = ($urandom_range(0, 9) == 0);
        send_char(b, dv, !badstop, badstop ? $urandom_range(0, 3 * d) : 0, 0);
        if (badstop) begin
          nferr++;
          pend.delete();
        end else begin
          pend.push_back(b);
          if (pend.size() == 1 && !b[7]) begin
            exp_q.push_back({b, 32'h0});
            pend.delete();
          end else if (pend.size() == 5) begin
            logic [39:0] v;
            v = '0;
            for (int k = 0; k < 5; k++) v = (v << 8) | 40'(pend[k]);
            exp_q.push_back(v);
            pend.delete();
          end
        end
        if (longgap) begin
          gap = 21 * d + $urandom_range(0, 5);
          pend.delete();
        end else begin
          gap = $urandom_range(badstop ? 2 : 0, 3 * d);
        end
        idle(gap);
      end
      idle(100);
      check("rand_stb_count", stb_cnt - s0, exp_q.size());
      check("rand_ferr_count", ferr_cnt - f0, nferr);
      for (int j = 0; j < exp_q.size(); j++) begin
        if (base + j < got_q.size())
          check($sformatf("rand_cmd%0d", j), got_q[base + j], exp_q[j]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
